// File: rtl/prog_sequencer.sv
// rtl/prog_sequencer.sv - program-memory instruction sequencer with Run/Done handshake and watchdog
module prog_sequencer #(
    parameter int AW      = 4,
    parameter int TIMEOUT = 15
) (
    input  logic          Clock,
    input  logic          Resetn,
    input  logic          start,
    input  logic          load_we,
    input  logic [AW-1:0] load_addr,
    input  logic [15:0]   load_data,
    input  logic          Done,
    output logic [15:0]   DIN,
    output logic          Run,
    output logic [AW-1:0] pc,
    output logic          busy,
    output logic          halted,
    output logic          timeout
);

    localparam int DEPTH = 1 << AW;
    localparam int CW    = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    // Abort fires on the WAIT cycle whose increment would bring the counter to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WAIT  = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    state_t         state_q, state_d;
    logic [AW-1:0]  pc_q, pc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           timeout_q, timeout_d;
    logic           run_d;

    logic [15:0]    mem_q [DEPTH];
    logic [15:0]    word;
    logic           is_halt;
    logic           is_mvi;
    logic           can_load;

    assign word     = mem_q[pc_q];
    assign is_halt  = (word[15:9] == 7'h7F);
    assign is_mvi   = !is_halt && (word[8:6] == 3'b001);
    assign can_load = (state_q == S_IDLE) || (state_q == S_HALT);

    // Program memory: written only while the sequencer is parked, never reset.
    always_ff @(posedge Clock) begin
        if (load_we && can_load) begin
            mem_q[load_addr] <= load_data;
        end
    end

    // Next-state, pc, watchdog and issue-strobe decode.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        run_d     = 1'b0;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start && !load_we) begin
                    pc_d      = '0;
                    timeout_d = 1'b0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    run_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                    if (is_mvi) begin
                        pc_d = pc_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (Done) begin
                    pc_d    = pc_q + 1'b1;
                    state_d = S_FETCH;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        timeout_d = 1'b1;
                        state_d   = S_HALT;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Control registers with asynchronous active-low clear.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign DIN     = word;
    assign Run     = run_d;
    assign pc      = pc_q;
    assign busy    = (state_q == S_FETCH) || (state_q == S_WAIT);
    assign halted  = (state_q == S_HALT);
    assign timeout = timeout_q;

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 Parameter AW, default 4: program-memory address width; DEPTH = 2^AW words of 16 bits.
REQ-002 Parameter TIMEOUT, default 15: maximum WAIT cycles without Done before abort.
REQ-003 Clock  input  1  sole clock; all state changes on its rising edge.
REQ-004 Resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  begin execution from address 0; level-sampled in IDLE/HALT only.
REQ-006 load_we  input  1  program-memory write strobe.
REQ-007 load_addr  input  AW  program-memory write address.
REQ-008 load_data  input  16  program-memory write data.
REQ-009 Done  input  1  processor instruction-complete strobe.
REQ-010 DIN  output  16  word presented to the processor: mem[pc].
REQ-011 Run  output  1  one-cycle instruction-issue strobe to the processor.
REQ-012 pc  output  AW  current program address.
REQ-013 busy  output  1  high in FETCH and WAIT.
REQ-014 halted  output  1  high in HALT.
REQ-015 timeout  output  1  sticky abort flag; cleared only by start or reset.

Function
REQ-016 States SHALL be IDLE, FETCH, WAIT and HALT, held in a registered state variable.
REQ-017 Word encoding: bits[15:9] == 7'h7F is HALT; otherwise bits[8:6] == 3'b001 is mvi (two-word); all other words are single-word instructions.
REQ-018 DIN SHALL equal mem[pc] in every state; Run SHALL be decoded from registered state and pc only, with no combinational path from Done.
REQ-019 IDLE: Run=0; on start=1 and load_we=0, pc<=0 and next state FETCH.
REQ-020 FETCH, word is HALT: Run=0, next state HALT, pc unchanged.
REQ-021 FETCH, word not HALT: Run=1 for exactly this cycle, watchdog counter<=0, next state WAIT; if the word is mvi, pc<=pc+1 so that DIN carries the immediate from the next cycle on.
REQ-022 WAIT: Run=0; on Done=1, pc<=pc+1 and next state FETCH; otherwise counter increments.
REQ-023 WAIT: when the counter reaches TIMEOUT without Done, timeout<=1 and next state HALT; Done on that same edge takes precedence over the abort.
REQ-024 Done SHALL be ignored in IDLE, FETCH and HALT.
REQ-025 pc arithmetic is modulo DEPTH: DEPTH-1 + 1 = 0, including an mvi at DEPTH-1 whose immediate is read from address 0.
REQ-026 HALT: halted=1, Run=0; on start=1 and load_we=0, pc<=0, timeout<=0, next state FETCH.
REQ-027 load_we=1 in IDLE or HALT writes load_data to mem[load_addr] at the edge; start in the same cycle SHALL be ignored.
REQ-028 load_we SHALL be ignored in FETCH and WAIT.
REQ-029 Program memory SHALL NOT be reset and SHALL retain contents across Resetn.

Reset
REQ-030 Resetn=0 SHALL immediately force state=IDLE, pc=0, Run=0, busy=0, halted=0, timeout=0 and counter=0, regardless of Clock.
REQ-031 Reset during WAIT SHALL abandon the in-flight instruction; a Done arriving after release in IDLE is ignored.

Verification
REQ-032 mem[0]=16'h0001, mem[1]=16'hFE00, start; Done 3 cycles after Run -> one Run pulse with DIN=16'h0001, pc=1, then halted=1 and no further Run.
REQ-033 mem[0]=16'h0040, mem[1]=16'h1234, mem[2]=16'hFE00 -> Run with DIN=16'h0040, next cycle DIN=16'h1234 and pc=1; after Done pc=2, then halted=1.
REQ-034 Done held low after a Run -> timeout=1 and halted=1 on the 15th WAIT cycle, busy=0; a subsequent start clears timeout and Run reissues mem[0].
REQ-035 16 words, no HALT word -> after Done at pc=15, pc=0 and Run reissues with DIN=mem[0].
REQ-036 Resetn pulsed low mid-WAIT -> Run=0, pc=0, busy=0 asynchronously; memory contents intact; load_we during busy leaves memory unchanged.
REQ-037 load_we=1 and start=1 in the same IDLE cycle -> the word is written, state stays IDLE, and Run does not assert.
